redux_loader: RTL
=================

# redux_loader

Boot-time program loader upstream of the redux core. Accepts a framed byte stream on a valid/ready input, writes the payload into the core's instruction memory through a dedicated write port, and holds the core in reset until a complete, checked frame has landed. After a successful load it releases the core. It re-arms on a `reload` pulse so a new program can be loaded without a global reset.

## Interface
- `MAGIC`, 8'hA5, frame start byte.
- `TIMEOUT`, 1024, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; the design has one clock, and reset is asynchronous and active-low.
- `in_valid`  in  1  stream byte present.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept; transfer = `in_valid & in_ready` at a rising edge.
- `reload`  in  1  single-cycle pulse; abort or restart and return to IDLE.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per byte.
- `imem_addr`  out  8  write address.
- `imem_wdata`  out  8  write data.
- `cpu_rst_n`  out  1  core reset, active-low; 0 except in RUN.
- `done`  out  1  load complete, core running.
- `error`  out  1  frame rejected.
- `err_code`  out  2  01 checksum mismatch, 10 timeout, 00 otherwise.

## Operation
- Frame format: `MAGIC`, LEN, LEN payload bytes, then CSUM (CSUM only when `LOADER_CHECKSUM_EN` is defined). LEN = 0 means 256 bytes.
- FSM states: IDLE, LEN, DATA, CSUM, RUN, ERR.
- IDLE: `in_ready`=1. A byte equal to `MAGIC` moves the FSM to LEN. Any other byte is consumed and discarded, with no write.
- LEN: accept one byte, load the 9-bit `remaining` counter (0 maps to 256), clear `addr` and `sum`, then go to DATA.
- DATA: each accepted byte is written to `addr`. After each byte: `addr`+1 (8-bit, wraps FF->00), `sum`+=byte (mod 256), `remaining`-1. When the last byte is accepted, go to CSUM, or to RUN if the checksum is compiled out.
- CSUM: accept one byte. If (`sum`+byte) mod 256 == 0, go to RUN; otherwise go to ERR with code 01.
- Timeout: a 16-bit idle counter runs in LEN, DATA and CSUM. It clears on every accepted byte and on every state entry. When it reaches `TIMEOUT`, go to ERR with code 10. It is inactive when `TIMEOUT`=0.
- RUN: `in_ready`=0 and `done`=1. `cpu_rst_n` rises one cycle after RUN is entered.
- ERR: `in_ready`=0, `error`=1, `err_code` held, `cpu_rst_n`=0. The FSM leaves ERR only on `reload` or reset.
- `reload` from any state: go to IDLE, clear counters, `err_code`, `done` and `error`. `cpu_rst_n` drops at the same edge.
- `reload` has priority over a simultaneous transfer: that byte is consumed and dropped, and no write is issued for it.

## Timing
- Reset values: state IDLE, `in_ready`=1, `imem_we`=0, `imem_addr`=00, `imem_wdata`=00, `cpu_rst_n`=0, `done`=0, `error`=0, `err_code`=00.
- Write latency: a byte accepted at edge k appears as `imem_we`/`imem_addr`/`imem_wdata` during cycle k..k+1. The write commits at edge k+1.
- `cpu_rst_n` is registered from state==RUN. It is therefore high no earlier than the edge after the last write commits.
- Throughput: one byte per cycle. `in_ready` is a pure decode of the state register and has no combinational path from `in_valid`.
- `rst_n` asserted mid-frame: immediate return to IDLE. Partially written instruction memory contents are left as they are.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CSUM state exists and a mismatch raises error code 01.
- `LOADER_CHECKSUM_EN` not defined: DATA goes directly to RUN, the `sum` register is removed, and code 01 never occurs.

## Structure
- `redux_pkg` holds:
  - the state enum;
  - `ERR_NONE`, `ERR_CSUM` and `ERR_TIMEOUT` constants;
  - the default `MAGIC`.
- One sub-module, `loader_timeout`: the idle counter with inputs `clear`, `enable` and `TIMEOUT`, and output `expired`.

## Test plan
- **Good frame:** A5 03 11 22 33 9A -> writes 00:11, 01:22, 02:33. `done`=1, `cpu_rst_n`=1 one cycle after RUN is entered, `in_ready`=0.
- **Bad checksum:** A5 03 11 22 33 9B -> `error`=1, `err_code`=01, `cpu_rst_n` stays 0. No further bytes are accepted until `reload`.
- **Leading garbage:** 00 FF 5A before a valid frame -> no `imem_we` for those bytes; the frame then loads normally.
- **Full 256-byte load:** LEN=00 -> 256 writes, `imem_addr` runs 00..FF, last `imem_wdata` matches, `done`=1.
- **Timeout:** `TIMEOUT`=16; A5 04 AA BB, then `in_valid`=0 -> after 16 idle cycles `error`=1, `err_code`=10.
- **Reload and reset interactions:**
  - `reload` in RUN -> `cpu_rst_n`=0 at that edge, state IDLE, a new frame loads.
  - `rst_n` low mid-DATA -> all outputs return to their reset values.

Source files
------------

// File: rtl/redux_loader_pkg.sv
// -----------------------------------------------------------------------------
// redux_pkg -- shared definitions for the redux boot loader.
//   state_e        : loader FSM encoding (IDLE, LEN, DATA, CSUM, RUN, ERR)
//   ERR_*          : error codes reported on err_code
//   LOADER_MAGIC   : default frame start byte
// -----------------------------------------------------------------------------
package redux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage

// File: rtl/redux_loader_if.sv
// -----------------------------------------------------------------------------
// redux_loader_if -- byte stream with valid/ready handshake.
//   in_valid : byte present (source -> sink)
//   in_data  : byte value   (source -> sink)
//   in_ready : sink accepts (sink -> source)
//   A transfer happens on a rising edge where in_valid & in_ready.
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface redux_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/redux_loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout -- idle counter guarding the inside of a frame.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (accepted byte or abort)
//   enable     : count only while a frame is in progress
//   expired    : the count reaches TIMEOUT on the coming edge
// TIMEOUT = 0 disables the counter (expired never asserts).
// -----------------------------------------------------------------------------
module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || !enable) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  // Flag one cycle early so the FSM leaves on the very edge the count
  // reaches TIMEOUT, i.e. after exactly TIMEOUT idle cycles.
  assign expired = (TIMEOUT != 0) && enable && !clear &&
                   (r_count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/redux_loader.sv
// -----------------------------------------------------------------------------
// redux_loader -- boot-time program loader for the redux core.
// Receives frames  MAGIC, LEN, LEN payload bytes [, CSUM]  on a valid/ready
// stream, writes the payload into instruction memory from address 0 and
// holds the core in reset until a complete frame has landed.
//
// Ports
//   clk, rst_n     : clock, async active-low reset
//   s_in           : byte stream (redux_loader_if.slave)
//   reload         : one-cycle pulse, abort/restart back to IDLE
//   imem_we        : instruction-memory write strobe (one cycle per byte)
//   imem_addr      : write address
//   imem_wdata     : write data
//   cpu_rst_n      : core reset, high only one cycle after RUN is entered
//   done           : load complete, core running
//   error          : frame rejected
//   err_code       : 01 checksum mismatch, 10 timeout, 00 otherwise
//
// Build option: define LOADER_CHECKSUM_EN to append and verify a trailing
// checksum byte (payload + CSUM == 0 mod 256).
// -----------------------------------------------------------------------------
module redux_loader
  import redux_pkg::*;
#(
  parameter logic [7:0] MAGIC   = LOADER_MAGIC,
  parameter int         TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  redux_loader_if.slave    s_in,
  input  logic             reload,
  output logic             imem_we,
  output logic [7:0]       imem_addr,
  output logic [7:0]       imem_wdata,
  output logic             cpu_rst_n,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);

  state_e      r_state;
  state_e      w_next;
  logic [1:0]  w_err_next;
  logic [8:0]  r_remaining;
  logic [7:0]  r_addr;
  logic        r_we;
  logic [7:0]  r_imem_addr;
  logic [7:0]  r_imem_wdata;
  logic        r_cpu_rst_n;
  logic [1:0]  r_err_code;
  logic        w_xfer;
  logic        w_busy;
  logic        w_expired;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  w_sum_chk;
  assign w_sum_chk = r_sum + s_in.in_data;
`endif

  // Frame in progress: the idle counter runs and the loader is listening.
  assign w_busy = (r_state == ST_LEN) || (r_state == ST_DATA) ||
                  (r_state == ST_CSUM);

  // Pure state decode; no path from in_valid.
  assign s_in.in_ready = (r_state == ST_IDLE) || w_busy;
  assign w_xfer        = s_in.in_valid && s_in.in_ready;

  // Every entry into LEN/DATA/CSUM coincides with an accepted byte, so
  // clearing on transfer also covers clearing on state entry.
  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_xfer || reload),
    .enable  (w_busy),
    .expired (w_expired)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_next     = r_state;
    w_err_next = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && (s_in.in_data == MAGIC)) w_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_xfer) begin
          w_next = ST_DATA;
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          if (r_remaining == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = ST_CSUM;
`else
            w_next = ST_RUN;
`endif
          end
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_xfer) begin
          if (w_sum_chk == 8'd0) begin
            w_next = ST_RUN;
          end else begin
            w_next     = ST_ERR;
            w_err_next = ERR_CSUM;
          end
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
`endif
      ST_RUN:  w_next = ST_RUN;
      ST_ERR:  w_next = ST_ERR;
      default: w_next = ST_IDLE;
    endcase
    // Abort wins over anything else, including a byte accepted this edge.
    if (reload) begin
      w_next     = ST_IDLE;
      w_err_next = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_err_code   <= ERR_NONE;
      r_cpu_rst_n  <= 1'b0;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_err_code  <= w_err_next;
      // Registered from the current state: the core leaves reset one cycle
      // after RUN is entered, after the last write has committed.
      r_cpu_rst_n <= !reload && (r_state == ST_RUN);
      r_we        <= 1'b0;
      if (reload) begin
        r_remaining <= '0;
        r_addr      <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum       <= '0;
`endif
      end else if (w_xfer) begin
        case (r_state)
          ST_LEN: begin
            // LEN = 0 encodes a full 256-byte payload.
            r_remaining <= {(s_in.in_data == 8'd0), s_in.in_data};
            r_addr      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
          end
          ST_DATA: begin
            r_we         <= 1'b1;
            r_imem_addr  <= r_addr;
            r_imem_wdata <= s_in.in_data;
            r_addr       <= r_addr + 8'd1;
            r_remaining  <= r_remaining - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= w_sum_chk;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign done       = (r_state == ST_RUN);
  assign error      = (r_state == ST_ERR);
  assign err_code   = r_err_code;

endmodule
